// File: rtl/mem_pkg.sv
// mem_pkg: RAM geometry, arbiter state encoding and port ids shared by the arbiter slice
package mem_pkg;
    localparam int ADDR_W = 4;
    localparam int DATA_W = 8;
    typedef enum logic [1:0] {IDLE = 2'd0, ACCESS = 2'd1, ACK = 2'd2} state_t;
    localparam logic PORT0 = 1'b0;
    localparam logic PORT1 = 1'b1;
endpackage

// File: rtl/arb2_pick.sv
// arb2_pick: combinational two-request winner select; pref breaks a tie
module arb2_pick
    import mem_pkg::*;
(
    input  logic req0,
    input  logic req1,
    input  logic pref,
    output logic gnt_valid,
    output logic gnt_id
);
    always_comb begin
        gnt_valid = req0 | req1;
        gnt_id    = (req0 && req1) ? pref : (req1 ? PORT1 : PORT0);
    end
endmodule

// File: rtl/ram_arbiter.sv
// ram_arbiter: two-port req/ack access controller for the 16x8 RAM, one access per 3 cycles
// Define RAM_ARBITER_ROUND_ROBIN_EN for round-robin arbitration; default is fixed priority to port 0.
module ram_arbiter
    import mem_pkg::*;
#(
    parameter int ADDR_W = mem_pkg::ADDR_W,
    parameter int DATA_W = mem_pkg::DATA_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              p0_req,
    input  logic              p0_we,
    input  logic [ADDR_W-1:0] p0_addr,
    input  logic [DATA_W-1:0] p0_wdata,
    output logic              p0_ack,
    output logic [DATA_W-1:0] p0_rdata,
    input  logic              p1_req,
    input  logic              p1_we,
    input  logic [ADDR_W-1:0] p1_addr,
    input  logic [DATA_W-1:0] p1_wdata,
    output logic              p1_ack,
    output logic [DATA_W-1:0] p1_rdata,
    output logic [ADDR_W-1:0] ram_address,
    output logic              ram_write_en,
    output logic              ram_read_en,
    output logic [DATA_W-1:0] ram_data_in,
    input  logic [DATA_W-1:0] ram_data_out,
    output logic              busy
);
    state_t            state, state_nx;
    logic              id, we, pref, gnt_valid, gnt_id, grant;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;

    assign grant = (state == IDLE) && gnt_valid;

`ifdef RAM_ARBITER_ROUND_ROBIN_EN
    logic ptr;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)     ptr <= PORT0;
        else if (grant) ptr <= ~gnt_id;
    end
    assign pref = ptr;
`else
    assign pref = PORT0;
`endif

    arb2_pick u_pick (
        .req0      (p0_req),
        .req1      (p1_req),
        .pref      (pref),
        .gnt_valid (gnt_valid),
        .gnt_id    (gnt_id)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = IDLE;
        state_nx = (state == IDLE)   ? (gnt_valid ? ACCESS : IDLE) :
                   (state == ACCESS) ? ACK : IDLE;
    end

    // Winner's fields are frozen here so the RAM never sees the requester ports directly
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            id       <= PORT0;
            we       <= 1'b0;
            addr     <= '0;
            wdata    <= '0;
            p0_rdata <= '0;
            p1_rdata <= '0;
        end else begin
            if (grant) begin
                id    <= gnt_id;
                we    <= gnt_id ? p1_we : p0_we;
                addr  <= gnt_id ? p1_addr : p0_addr;
                wdata <= gnt_id ? p1_wdata : p0_wdata;
            end
            if (ram_read_en && id == PORT0) p0_rdata <= ram_data_out;
            if (ram_read_en && id == PORT1) p1_rdata <= ram_data_out;
        end
    end

    // Enables decode straight from state so an async reset drops them at once
    assign ram_address  = addr;
    assign ram_data_in  = wdata;
    assign ram_write_en = (state == ACCESS) && we;
    assign ram_read_en  = (state == ACCESS) && !we;
    assign p0_ack       = (state == ACK) && (id == PORT0);
    assign p1_ack       = (state == ACK) && (id == PORT1);
    assign busy         = (state != IDLE);
endmodule
